// File: rtl/apb2axi_rd_slicer_if.sv
// Beat-in / word-out stream bundle for apb2axi_rd_slicer.
// The master side feeds AXI read beats and accepts APB words; the slicer is the slave.
interface apb2axi_rd_slicer_if #(
    parameter int TAG_NUM    = 4,
    parameter int AXI_DATA_W = 64,
    parameter int APB_DATA_W = 32,
    localparam int TAG_W     = (TAG_NUM > 1) ? $clog2(TAG_NUM) : 1
);
    logic                                 in_vld;
    logic                                 in_rdy;
    logic [TAG_W-1:0]                     in_tag;
    logic [AXI_DATA_W-1:0]                in_data;
    logic [1:0]                           in_resp;
    logic                                 in_last;
    logic [TAG_NUM-1:0]                   out_vld;
    logic [TAG_NUM-1:0][APB_DATA_W-1:0]   out_data;
    logic [TAG_NUM-1:0][1:0]              out_resp;
    logic [TAG_NUM-1:0]                   out_last;
    logic [TAG_NUM-1:0]                   out_rdy;

    modport master (
        output in_vld, in_tag, in_data, in_resp, in_last, out_rdy,
        input  in_rdy, out_vld, out_data, out_resp, out_last
    );

    modport slave (
        input  in_vld, in_tag, in_data, in_resp, in_last, out_rdy,
        output in_rdy, out_vld, out_data, out_resp, out_last
    );
endinterface

// File: rtl/apb2axi_rd_slicer.sv
// Per-TAG AXI read-beat FIFOs drained as APB-width words with narrow-lane selection.
// Optional sticky error flag per TAG: define APB2AXI_RD_ERR_STICKY_EN.
module apb2axi_rd_slicer #(
    parameter int TAG_NUM    = 4,
    parameter int AXI_DATA_W = 64,
    parameter int APB_DATA_W = 32,
    parameter int DEPTH      = 4,
    localparam int BB        = AXI_DATA_W / 8,
    localparam int BBL       = $clog2(BB),
    localparam int AW        = (BB > 1) ? BBL : 1,
    localparam int CW        = $clog2(DEPTH + 1)
) (
    input  logic                          pclk,
    input  logic                          preset,
    apb2axi_rd_slicer_if.slave            bus,
    input  logic [TAG_NUM-1:0][2:0]       tag_size,
    input  logic [TAG_NUM-1:0][AW-1:0]    tag_addr_lo,
    input  logic [TAG_NUM-1:0]            tag_flush,
    output logic [TAG_NUM-1:0][CW-1:0]    tag_count
`ifdef APB2AXI_RD_ERR_STICKY_EN
    ,
    output logic [TAG_NUM-1:0]            err_sticky
`endif
);
    localparam int APBL  = $clog2(APB_DATA_W);
    localparam int PW    = $clog2(DEPTH);
    localparam int RATIO = AXI_DATA_W / APB_DATA_W;
    localparam int SW    = (RATIO > 1) ? $clog2(RATIO) : 1;

    logic [AXI_DATA_W-1:0] mem_data [TAG_NUM][DEPTH];
    logic [1:0]            mem_resp [TAG_NUM][DEPTH];
    logic                  mem_last [TAG_NUM][DEPTH];

    logic [PW-1:0]         head      [TAG_NUM];
    logic [PW-1:0]         tail      [TAG_NUM];
    logic [CW-1:0]         count     [TAG_NUM];
    logic [SW-1:0]         slice_idx [TAG_NUM];
    logic [AW-1:0]         beat_idx  [TAG_NUM];

    logic [TAG_NUM-1:0]    slice_last;
    logic [TAG_NUM-1:0]    hs;
    logic [TAG_NUM-1:0]    push;
    logic [TAG_NUM-1:0]    pop;

    function automatic int size_log(input logic [2:0] size);
        return (int'(size) > BBL) ? BBL : int'(size);
    endfunction

    function automatic int words_per_beat(input int szl);
        return (szl + 3 > APBL) ? (1 << (szl + 3 - APBL)) : 1;
    endfunction

    // Start address is aligned down to the transfer size before stepping per beat.
    function automatic int lane_offset(input logic [AW-1:0] addr_lo, input int szl,
                                       input logic [AW-1:0] beat);
        int start;
        start = (int'(addr_lo) >> szl) << szl;
        return (start + (int'(beat) << szl)) & (BB - 1);
    endfunction

    function automatic logic [APB_DATA_W-1:0] slice_word(input logic [AXI_DATA_W-1:0] beat,
                                                         input int off, input int szl,
                                                         input int idx);
        logic [AXI_DATA_W-1:0] sh;
        logic [APB_DATA_W-1:0] mask;
        sh   = beat >> (off * 8 + idx * APB_DATA_W);
        mask = '1;
        if (szl + 3 < APBL)
            mask = mask >> (APB_DATA_W - (8 << szl));
        return sh[APB_DATA_W-1:0] & mask;
    endfunction

    always_comb begin
        bus.in_rdy = 1'b0;
        if (int'(bus.in_tag) < TAG_NUM)
            bus.in_rdy = (count[bus.in_tag] < CW'(DEPTH)) && !tag_flush[bus.in_tag];
    end

    always_comb begin
        for (int t = 0; t < TAG_NUM; t++) begin
            slice_last[t]   = (int'(slice_idx[t]) == words_per_beat(size_log(tag_size[t])) - 1);
            hs[t]           = (count[t] != '0) && bus.out_rdy[t];
            push[t]         = bus.in_vld && bus.in_rdy && (int'(bus.in_tag) == t);
            pop[t]          = hs[t] && slice_last[t] && !tag_flush[t];
            tag_count[t]    = count[t];
            bus.out_vld[t]  = (count[t] != '0);
            bus.out_data[t] = '0;
            bus.out_resp[t] = '0;
            bus.out_last[t] = 1'b0;
            if (count[t] != '0) begin
                bus.out_data[t] = slice_word(mem_data[t][head[t]],
                                             lane_offset(tag_addr_lo[t], size_log(tag_size[t]), beat_idx[t]),
                                             size_log(tag_size[t]), int'(slice_idx[t]));
                bus.out_resp[t] = mem_resp[t][head[t]];
                bus.out_last[t] = mem_last[t][head[t]] && slice_last[t];
            end
        end
    end

    // Beat storage carries no reset; validity is tracked by count alone.
    always_ff @(posedge pclk) begin
        for (int t = 0; t < TAG_NUM; t++) begin
            if (push[t]) begin
                mem_data[t][tail[t]] <= bus.in_data;
                mem_resp[t][tail[t]] <= bus.in_resp;
                mem_last[t][tail[t]] <= bus.in_last;
            end
        end
    end

    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            for (int t = 0; t < TAG_NUM; t++) begin
                head[t]      <= '0;
                tail[t]      <= '0;
                count[t]     <= '0;
                slice_idx[t] <= '0;
                beat_idx[t]  <= '0;
            end
        end else begin
            for (int t = 0; t < TAG_NUM; t++) begin
                if (tag_flush[t]) begin
                    head[t]      <= '0;
                    tail[t]      <= '0;
                    count[t]     <= '0;
                    slice_idx[t] <= '0;
                    beat_idx[t]  <= '0;
                end else begin
                    if (push[t])
                        tail[t] <= tail[t] + PW'(1);
                    if (hs[t]) begin
                        if (slice_last[t]) begin
                            head[t]      <= head[t] + PW'(1);
                            slice_idx[t] <= '0;
                            beat_idx[t]  <= mem_last[t][head[t]] ? '0 : beat_idx[t] + AW'(1);
                        end else begin
                            slice_idx[t] <= slice_idx[t] + SW'(1);
                        end
                    end
                    count[t] <= count[t] + CW'(push[t]) - CW'(pop[t]);
                end
            end
        end
    end

`ifdef APB2AXI_RD_ERR_STICKY_EN
    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            err_sticky <= '0;
        end else begin
            for (int t = 0; t < TAG_NUM; t++) begin
                if (tag_flush[t])
                    err_sticky[t] <= 1'b0;
                else if (push[t] && bus.in_resp[1])
                    err_sticky[t] <= 1'b1;
            end
        end
    end
`endif

endmodule
